rpc2_ctrl_resp_router: RTL and testbench

RPC2_CTRL_RESP_ROUTER -- requirements
Module: rpc2_ctrl_resp_router

---
 rtl/rpc2_ctrl_resp_router_if.sv | 46 ++++
 rtl/rpc2_ctrl_resp_router.sv | 100 ++++++++++
 tb/tb_rpc2_ctrl_resp_router.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpc2_ctrl_resp_router_if.sv
// Bundle between the arbiter/controller core (master side) and the response
// router (slave side): issue record, response stream and the two port outputs.
interface rpc2_ctrl_resp_router_if #(
    parameter int DATA_W = 32
);
    logic              push_valid;
    logic              push_sel;
    logic              push_ready;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_ready;

    logic              out0_valid;
    logic [DATA_W-1:0] out0_data;
    logic              out0_last;
    logic              out0_ready;

    logic              out1_valid;
    logic [DATA_W-1:0] out1_data;
    logic              out1_last;
    logic              out1_ready;

    modport master (
        output push_valid, push_sel,
        input  push_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        input  out0_valid, out0_data, out0_last,
        output out0_ready,
        input  out1_valid, out1_data, out1_last,
        output out1_ready
    );

    modport slave (
        input  push_valid, push_sel,
        output push_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        output out0_valid, out0_data, out0_last,
        input  out0_ready,
        output out1_valid, out1_data, out1_last,
        input  out1_ready
    );
endinterface

// File: rtl/rpc2_ctrl_resp_router.sv
// Routes response beats from the controller core back to the port that issued
// the request, using an in-order FIFO of 1-bit port selectors.
module rpc2_ctrl_resp_router #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rpc2_ctrl_resp_router_if.slave bus,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_unexpected,
    input  logic                   err_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DEPTH-1:0]  fifo_q, fifo_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    cnt_t              count_q, count_d;
    logic              err_q, err_d;

    logic              full;
    logic              empty;
    logic              head;
    logic              do_push;
    logic              do_pop;
    logic [DATA_W-1:0] rsp_data;

    // Emptiness is judged on registered occupancy, so an entry written this
    // cycle cannot steer a beat until the next one.
    assign full     = (count_q == cnt_t'(DEPTH));
    assign empty    = (count_q == '0);
    assign head     = fifo_q[rd_ptr_q];
    assign rsp_data = bus.rsp_data;

    assign bus.push_ready = !full;
    assign bus.out0_valid = !empty && bus.rsp_valid && !head;
    assign bus.out1_valid = !empty && bus.rsp_valid &&  head;
    assign bus.rsp_ready  = !empty && (head ? bus.out1_ready : bus.out0_ready);
    assign bus.out0_data  = rsp_data;
    assign bus.out1_data  = rsp_data;
    assign bus.out0_last  = bus.rsp_last;
    assign bus.out1_last  = bus.rsp_last;

    assign do_push = bus.push_valid && !full;
    assign do_pop  = bus.rsp_valid && bus.rsp_ready && bus.rsp_last;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned and no latch is inferred.
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            fifo_d[wr_ptr_q] = bus.push_sel;
            wr_ptr_d         = wr_ptr_q + ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // A stray beat wins over a same-cycle clear so it is never lost.
        err_d = (bus.rsp_valid && empty) || (err_q && !err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: selector storage is not reset; zero occupancy already makes stale entries unreachable.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign outstanding    = count_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_rpc2_ctrl_resp_router.sv
// Scoreboard bench for rpc2_ctrl_resp_router: a selector model predicts the
// destination of every beat; a negedge monitor pops and compares transfers.
module tb_rpc2_ctrl_resp_router;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr;
    logic [2:0] outstanding;
    logic       err_unexpected;

    rpc2_ctrl_resp_router_if #(.DATA_W(DATA_W)) bus ();

    rpc2_ctrl_resp_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t sb[$];
    logic  mdl[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sb_pop(input logic port, input logic [DATA_W-1:0] data, input logic last);
        beat_t e;
        check("sb_pending", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat_port", 64'(port), 64'(e.port));
            check("beat_data", 64'(data), 64'(e.data));
            check("beat_last", 64'(last), 64'(e.last));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out0_valid || bus.out1_valid)
                check("valid_onehot", 64'(bus.out0_valid & bus.out1_valid), 64'(0));
            if (bus.out0_valid && bus.out0_ready) sb_pop(1'b0, bus.out0_data, bus.out0_last);
            if (bus.out1_valid && bus.out1_ready) sb_pop(1'b1, bus.out1_data, bus.out1_last);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic sel);
        logic acc;
        acc = (mdl.size() < DEPTH);
        bus.push_valid = 1'b1;
        bus.push_sel   = sel;
        @(negedge clk);
        check("push_ready", 64'(bus.push_ready), 64'(acc));
        tick();
        if (acc) mdl.push_back(sel);
        bus.push_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        beat_t e;
        logic  ok;
        e = '{port: mdl[0], data: d, last: last};
        sb.push_back(e);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = d;
        bus.rsp_last  = last;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.rsp_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("beat_accepted", 64'(ok), 64'(1));
        tick();
        if (ok && last) void'(mdl.pop_front());
        bus.rsp_valid = 1'b0;
    endtask

    task automatic check_occ(input string tag);
        @(negedge clk);
        check(tag, 64'(outstanding), 64'(mdl.size()));
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_sel   = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_data   = '0;
        bus.rsp_last   = 1'b0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        err_clr        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_push_ready", 64'(bus.push_ready), 64'(1));
        check("rst_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        check("rst_err", 64'(err_unexpected), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // In-order single-beat routing 0,1,0
        do_push(1'b0);
        do_push(1'b1);
        do_push(1'b0);
        check_occ("occ_after_3_push");
        tick();
        send_beat(32'hA000_0001, 1'b1);
        check_occ("occ_after_pop1");
        tick();
        send_beat(32'hA000_0002, 1'b1);
        send_beat(32'hA000_0003, 1'b1);
        check_occ("occ_after_pop3");
        tick();

        // Multi-beat to port 1 with backpressure
        do_push(1'b1);
        send_beat(32'hB000_0001, 1'b0);
        bus.out1_ready = 1'b0;
        bus.rsp_valid  = 1'b1;
        bus.rsp_data   = 32'hB000_0002;
        bus.rsp_last   = 1'b0;
        @(negedge clk);
        check("stall_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        check("stall_out1_valid", 64'(bus.out1_valid), 64'(1));
        check("stall_out0_valid", 64'(bus.out0_valid), 64'(0));
        check("stall_occ", 64'(outstanding), 64'(1));
        tick();
        bus.out1_ready = 1'b1;
        send_beat(32'hB000_0002, 1'b0);
        send_beat(32'hB000_0003, 1'b0);
        check_occ("occ_before_last");
        tick();
        send_beat(32'hB000_0004, 1'b1);
        check_occ("occ_after_last");
        tick();

        // Full FIFO: fifth push dropped while a pop happens
        do_push(1'b0);
        do_push(1'b1);
        do_push(1'b0);
        do_push(1'b1);
        check_occ("occ_full");
        check("full_push_ready", 64'(bus.push_ready), 64'(0));
        tick();
        sb.push_back('{port: mdl[0], data: 32'hC000_0001, last: 1'b1});
        bus.push_valid = 1'b1;
        bus.push_sel   = 1'b1;
        bus.rsp_valid  = 1'b1;
        bus.rsp_data   = 32'hC000_0001;
        bus.rsp_last   = 1'b1;
        @(negedge clk);
        check("full_pop_push_ready", 64'(bus.push_ready), 64'(0));
        check("full_pop_rsp_ready", 64'(bus.rsp_ready), 64'(1));
        tick();
        bus.push_valid = 1'b0;
        bus.rsp_valid  = 1'b0;
        void'(mdl.pop_front());
        check_occ("occ_after_drop");
        check("push_ready_reopen", 64'(bus.push_ready), 64'(1));
        tick();
        send_beat(32'hC000_0002, 1'b1);
        send_beat(32'hC000_0003, 1'b1);
        send_beat(32'hC000_0004, 1'b1);
        check_occ("occ_drained");
        tick();

        // Unexpected beat and error clear
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_0001;
        bus.rsp_last  = 1'b1;
        @(negedge clk);
        check("unexp_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        check("unexp_out0_valid", 64'(bus.out0_valid), 64'(0));
        check("unexp_out1_valid", 64'(bus.out1_valid), 64'(0));
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("err_set", 64'(err_unexpected), 64'(1));
        tick();
        bus.rsp_valid = 1'b1;
        err_clr       = 1'b1;
        tick();
        bus.rsp_valid = 1'b0;
        err_clr       = 1'b0;
        @(negedge clk);
        check("err_set_beats_clr", 64'(err_unexpected), 64'(1));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(err_unexpected), 64'(0));
        tick();

        // Push and beat in the same cycle from empty: no forwarding
        bus.push_valid = 1'b1;
        bus.push_sel   = 1'b0;
        bus.rsp_valid  = 1'b1;
        bus.rsp_data   = 32'hE000_0001;
        bus.rsp_last   = 1'b1;
        @(negedge clk);
        check("bypass_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        check("bypass_out0_valid", 64'(bus.out0_valid), 64'(0));
        tick();
        bus.push_valid = 1'b0;
        mdl.push_back(1'b0);
        sb.push_back('{port: 1'b0, data: 32'hE000_0001, last: 1'b1});
        @(negedge clk);
        check("next_out0_valid", 64'(bus.out0_valid), 64'(1));
        check("next_rsp_ready", 64'(bus.rsp_ready), 64'(1));
        tick();
        bus.rsp_valid = 1'b0;
        void'(mdl.pop_front());
        check_occ("occ_after_bypass");
        check("bypass_err", 64'(err_unexpected), 64'(1));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset mid-transaction with two entries outstanding
        do_push(1'b0);
        do_push(1'b1);
        check_occ("occ_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hF000_0001;
        bus.rsp_last  = 1'b1;
        #1;
        mdl.delete();
        check("arst_outstanding", 64'(outstanding), 64'(0));
        check("arst_push_ready", 64'(bus.push_ready), 64'(1));
        check("arst_out0_valid", 64'(bus.out0_valid), 64'(0));
        check("arst_out1_valid", 64'(bus.out1_valid), 64'(0));
        check("arst_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("post_rst_err", 64'(err_unexpected), 64'(1));

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
